// File: rtl/opcode_fetch_seq.sv
// Instruction fetch sequencer: owns the PC, resolves the 0xCB prefix, collects immediates and
// hands a complete instruction bundle to execute. Define ILLEGAL_OP_TRAP_EN for the illegal-opcode trap.
module opcode_fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [7:0]  opcode,
  output logic        cb_prefix,
  output logic [15:0] imm,
  output logic [15:0] op_pc,
  input  logic        jump_valid,
  input  logic [15:0] jump_addr,
  output logic        illegal
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_CB,
    FETCH_LO,
    FETCH_HI,
    PRESENT
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic        cb_reg, cb_next;
  logic [15:0] imm_reg, imm_next;
  logic [15:0] op_pc_reg, op_pc_next;
  logic        fetching;

  // Total instruction length in bytes for a non-CB first byte.
  function automatic logic [1:0] op_len(input logic [7:0] b);
    logic [1:0] len;
    case (b)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                              len = 2'd2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:                len = 2'd3;
      default:                                                 len = 2'd1;
    endcase
    return len;
  endfunction

`ifdef ILLEGAL_OP_TRAP_EN
  function automatic logic is_illegal(input logic [7:0] b);
    logic ill;
    case (b)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: ill = 1'b1;
      default:                           ill = 1'b0;
    endcase
    return ill;
  endfunction
`endif

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    opcode_next = opcode_reg;
    cb_next     = cb_reg;
    imm_next    = imm_reg;
    op_pc_next  = op_pc_reg;
    // Redirect wins over any byte arriving in the same cycle.
    if (jump_valid) begin
      state_next = FETCH_OP;
      pc_next    = jump_addr;
    end else begin
      case (state_reg)
        FETCH_OP: if (mem_ready) begin
          pc_next     = pc_reg + 16'd1;
          op_pc_next  = pc_reg;
          opcode_next = mem_data;
          cb_next     = 1'b0;
          imm_next    = 16'h0000;
          if (mem_data == 8'hCB) state_next = FETCH_CB;
`ifdef ILLEGAL_OP_TRAP_EN
          else if (is_illegal(mem_data)) state_next = TRAP;
`endif
          else if (op_len(mem_data) != 2'd1) state_next = FETCH_LO;
          else state_next = PRESENT;
        end
        FETCH_CB: if (mem_ready) begin
          pc_next     = pc_reg + 16'd1;
          opcode_next = mem_data;
          cb_next     = 1'b1;
          state_next  = PRESENT;
        end
        FETCH_LO: if (mem_ready) begin
          pc_next       = pc_reg + 16'd1;
          imm_next[7:0] = mem_data;
          state_next    = (op_len(opcode_reg) == 2'd3) ? FETCH_HI : PRESENT;
        end
        FETCH_HI: if (mem_ready) begin
          pc_next        = pc_reg + 16'd1;
          imm_next[15:8] = mem_data;
          state_next     = PRESENT;
        end
        PRESENT: if (op_ready) state_next = FETCH_OP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FETCH_OP;
      pc_reg     <= RESET_PC;
      opcode_reg <= 8'h00;
      cb_reg     <= 1'b0;
      imm_reg    <= 16'h0000;
      op_pc_reg  <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      opcode_reg <= opcode_next;
      cb_reg     <= cb_next;
      imm_reg    <= imm_next;
      op_pc_reg  <= op_pc_next;
    end
  end

  assign fetching  = (state_reg == FETCH_OP) || (state_reg == FETCH_CB) ||
                     (state_reg == FETCH_LO) || (state_reg == FETCH_HI);
  // No read request while reset is asserted, whatever the current state.
  assign mem_rd    = fetching && !rst;
  assign mem_addr  = pc_reg;
  assign op_valid  = (state_reg == PRESENT);
  assign opcode    = opcode_reg;
  assign cb_prefix = cb_reg;
  assign imm       = imm_reg;
  assign op_pc     = op_pc_reg;
`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal   = (state_reg == TRAP);
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_fetch_seq.sv
// Randomized self-checking bench for opcode_fetch_seq: directed scenarios followed by random
// memory/handshake/redirect traffic, scored against an instruction-level reference model.
module tb_opcode_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_data;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic [15:0] imm;
  logic [15:0] op_pc;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        illegal;

  opcode_fetch_seq #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready),
    .mem_data(mem_data), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .cb_prefix(cb_prefix), .imm(imm), .op_pc(op_pc), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] LEN2 [26] = '{8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
                                       8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
                                       8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                                       8'hE0, 8'hF0, 8'hE8, 8'hF8};
  localparam logic [7:0] LEN3 [17] = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
                                       8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
                                       8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA};
  localparam logic [7:0] ILL [11]  = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
                                       8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

  logic [7:0]  mem [65536];
  int          len_tbl [256];
  bit          ill_tbl [256];
  logic [15:0] exp_pc;        // address of the instruction the DUT should be working on
  bit          chk_after;     // a transfer or redirect happened at the last edge
  bit          trap_escape;
  int          wait_lo, wait_hi, wait_left;
  int          n_xfer;
  int          vectors, miscompares;
  int          n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference decode of the instruction starting at pc, straight from memory contents.
  task automatic decode(input logic [15:0] pc, output logic [7:0] op, output logic cb,
                        output logic [15:0] im, output int len, output bit ill);
    logic [7:0] b0;
    b0  = mem[pc];
    ill = 1'b0;
    if (b0 == 8'hCB) begin
      op = mem[pc + 16'd1]; cb = 1'b1; im = 16'h0000; len = 2;
    end else begin
      op  = b0; cb = 1'b0; len = len_tbl[b0];
      ill = ill_tbl[b0];
      if (len == 2)      im = {8'h00, mem[pc + 16'd1]};
      else if (len == 3) im = {mem[pc + 16'd2], mem[pc + 16'd1]};
      else               im = 16'h0000;
    end
  endtask

  // One clock: sample and score at the falling edge, then drive the next edge's inputs.
  task automatic tick(input bit rdy, input bit jv, input logic [15:0] ja);
    logic [7:0] e_op; logic e_cb; logic [15:0] e_imm; int e_len; bit e_ill;
    @(negedge clk);
    decode(exp_pc, e_op, e_cb, e_imm, e_len, e_ill);
    if (chk_after) begin
      check("next_addr", mem_addr, exp_pc);
      check("valid_drop", op_valid, 0);
      check("illegal_clr", illegal, 0);
      chk_after = 0;
    end
    check("rd_vs_state", mem_rd, !(op_valid || illegal));
    if (op_valid) begin
      check("opcode", opcode, e_op);
      check("cb_prefix", cb_prefix, e_cb);
      check("imm", imm, e_imm);
      check("op_pc", op_pc, exp_pc);
    end
`ifdef ILLEGAL_OP_TRAP_EN
    if (illegal) begin
      check("trap_first", {31'b0, e_ill}, 1);
      check("trap_pc", mem_addr, exp_pc + 16'd1);
      check("trap_valid", op_valid, 0);
      if (trap_escape && !jv) begin jv = 1'b1; ja = 16'($urandom); end
    end
`else
    check("illegal_tied", illegal, 0);
`endif
    mem_data = mem[mem_addr];
    if (mem_rd && wait_left == 0) begin
      mem_ready = 1'b1;
      wait_left = int'($urandom_range(wait_hi, wait_lo));
    end else begin
      mem_ready = 1'b0;
      if (mem_rd && wait_left > 0) wait_left--;
    end
    op_ready = rdy; jump_valid = jv; jump_addr = ja;
    if (op_valid && rdy) n_xfer++;
    if (jv) begin
      exp_pc = ja; chk_after = 1;
    end else if (op_valid && rdy) begin
      exp_pc = exp_pc + 16'(e_len); chk_after = 1;
    end
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    do begin tick(1'b0, 1'b0, 16'h0000); cycles++; end while (!op_valid && cycles < 200);
    check({tag, "_seen"}, op_valid, 1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; n_xfer = 0;
    wait_lo = 0; wait_hi = 0; wait_left = 0; chk_after = 0; trap_escape = 1;
    foreach (len_tbl[i]) begin len_tbl[i] = 1; ill_tbl[i] = 0; end
    foreach (LEN2[i]) len_tbl[LEN2[i]] = 2;
    foreach (LEN3[i]) len_tbl[LEN3[i]] = 3;
`ifdef ILLEGAL_OP_TRAP_EN
    foreach (ILL[i]) ill_tbl[ILL[i]] = 1;
`endif
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0000] = 8'h00;
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
    mem[16'h0300] = 8'hC3; mem[16'h0301] = 8'hAD; mem[16'h0302] = 8'hDE;
    mem[16'hFFFF] = 8'h3E;
    mem[16'h0400] = 8'h3E; mem[16'h0401] = 8'h77; mem[16'h0500] = 8'h00;
    mem[16'h0600] = 8'hD3;

    // Reset
    rst = 1'b1; op_ready = 1'b0; jump_valid = 1'b0; jump_addr = 16'h0000;
    mem_ready = 1'b0; mem_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_valid", op_valid, 0);
    check("rst_opcode", opcode, 0);
    check("rst_cb", cb_prefix, 0);
    check("rst_imm", imm, 0);
    check("rst_op_pc", op_pc, 0);
    check("rst_illegal", illegal, 0);
    check("rst_addr", mem_addr, 16'h0000);
    rst = 1'b0; exp_pc = 16'h0000;

    // 1-byte NOP at reset PC, zero-wait memory
    wait_valid("t1", n);
    check("t1_latency", n, 2);
    check("t1_opcode", opcode, 8'h00);
    check("t1_imm", imm, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t1_pc_after", mem_addr, 16'h0001);

    // 3-byte immediate
    tick(1'b0, 1'b1, 16'h0100);
    wait_valid("t2", n);
    check("t2_latency", n, 4);
    check("t2_imm", imm, 16'h1234);
    check("t2_op_pc", op_pc, 16'h0100);
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t2_pc_after", mem_addr, 16'h0103);

    // CB-prefixed
    tick(1'b0, 1'b1, 16'h0200);
    wait_valid("t3", n);
    check("t3_cb", cb_prefix, 1);
    check("t3_opcode", opcode, 8'h37);
    check("t3_imm", imm, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t3_pc_after", mem_addr, 16'h0202);

    // 3 wait states per byte, execute stalls 5 cycles
    wait_lo = 3; wait_hi = 3;
    tick(1'b0, 1'b1, 16'h0300);
    wait_left = 3;
    wait_valid("t4", n);
    check("t4_latency", n, 13);
    repeat (5) tick(1'b0, 1'b0, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000);
    check("t4_hold", op_valid, 1);
    tick(1'b0, 1'b0, 16'h0000);
    check("t4_drop", op_valid, 0);

    // PC wrap across 0xFFFF, then redirect mid-immediate
    wait_lo = 0; wait_hi = 0;
    tick(1'b0, 1'b1, 16'hFFFF);
    wait_left = 0;
    wait_valid("t5", n);
    check("t5_imm", imm, 16'h0055 & {8'h00, mem[16'h0000]});
    check("t5_op_pc", op_pc, 16'hFFFF);
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t5_pc_wrap", mem_addr, 16'h0001);
    tick(1'b0, 1'b1, 16'h0400);
    tick(1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 16'h0500);
    check("t5_ready_in_jump", mem_ready, 1);
    tick(1'b0, 1'b0, 16'h0000);
    check("t5_redirect_addr", mem_addr, 16'h0500);
    wait_valid("t5b", n);
    check("t5b_op_pc", op_pc, 16'h0500);
    check("t5b_opcode", opcode, 8'h00);
    tick(1'b1, 1'b0, 16'h0000);

    // Opcode D3
`ifdef ILLEGAL_OP_TRAP_EN
    trap_escape = 0;
    tick(1'b0, 1'b1, 16'h0600);
    repeat (4) tick(1'b0, 1'b0, 16'h0000);
    check("t6_illegal", illegal, 1);
    check("t6_mem_rd", mem_rd, 0);
    tick(1'b0, 1'b1, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t6_illegal_clr", illegal, 0);
    check("t6_resume", mem_rd, 1);
    trap_escape = 1;
`else
    tick(1'b0, 1'b1, 16'h0600);
    wait_valid("t6", n);
    check("t6_opcode", opcode, 8'hD3);
    check("t6_imm", imm, 16'h0000);
    tick(1'b1, 1'b0, 16'h0000);
    tick(1'b0, 1'b0, 16'h0000);
    check("t6_pc_after", mem_addr, 16'h0601);
`endif

    // Random traffic: waits, stalls, redirects
    wait_lo = 0; wait_hi = 2;
    n_xfer = 0;
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(9, 0) < 7, $urandom_range(99, 0) < 3, 16'($urandom));
    check("rand_progress", {31'b0, n_xfer > 50}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
